// File: rtl/banner_scroller_if.sv
// Row-read channel between the LED row driver, the banner scroller and the
// external registered-address banner ROM.
interface banner_scroller_if #(
    parameter int IMG_W  = 70,
    parameter int WIN_W  = 32,
    parameter int ADDR_W = 5
) ();
    logic              row_req;
    logic [ADDR_W-1:0] row_addr;
    logic [WIN_W-1:0]  row_data;
    logic              row_valid;
    logic [ADDR_W-1:0] rom_addr;
    logic [IMG_W-1:0]  rom_data;

    modport slave (
        input  row_req, row_addr, rom_data,
        output row_data, row_valid, rom_addr
    );

    modport master (
        output row_req, row_addr, rom_data,
        input  row_data, row_valid, rom_addr
    );
endinterface

// File: rtl/banner_scroller.sv
// Serves a scrolling or blinking WIN_W-column window of an IMG_W x IMG_H
// ROM-resident banner bitmap to the LED row driver, two cycles after request.
module banner_scroller #(
    parameter int IMG_W  = 70,
    parameter int IMG_H  = 15,
    parameter int WIN_W  = 32,
    parameter int ADDR_W = 5,
    parameter int PRE_W  = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [PRE_W-1:0] speed,
    output logic [7:0]       offset,
    output logic             wrap,
    output logic             busy,
    banner_scroller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
    typedef enum logic [1:0] {M_STATIC, M_WRAP, M_GAP, M_BLINK} mode_t;

    localparam int         GAP_PERIOD = IMG_W + WIN_W;
    localparam logic [7:0] WRAP_LAST  = 8'(IMG_W - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_PERIOD - 1);

    state_t           state;
    mode_t            mode_q;
    logic [PRE_W-1:0] pre_cnt;
    logic             blank;
    logic             tick;

    logic [7:0]        off_p1;
    logic              gap_p1;
    logic              zero_p1;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [WIN_W-1:0]  win_p1;
    logic              vld_p2;
    logic [WIN_W-1:0]  data_p2;

    function automatic logic [7:0] step_offset(input logic [7:0] off, input logic [7:0] last);
        return (off == last) ? 8'd0 : off + 8'd1;
    endfunction

    function automatic logic row_in_range(input logic [ADDR_W-1:0] row);
        return int'(row) < IMG_H;
    endfunction

    // Column j of the window lands at bit WIN_W-1-j; in GAP mode columns past
    // the image are the blank gap.
    function automatic logic [WIN_W-1:0] window(input logic [IMG_W-1:0] img,
                                                input logic [7:0] off,
                                                input logic gap);
        logic [WIN_W-1:0] w;
        logic [IMG_W-1:0] sh;
        logic             b;
        int               c;
        w = '0;
        for (int j = 0; j < WIN_W; j++) begin
            c = int'(off) + j;
            if (gap) begin
                if (c >= GAP_PERIOD) c -= GAP_PERIOD;
            end else if (c >= IMG_W) begin
                c -= IMG_W;
            end
            sh = img >> (IMG_W - 1 - c);
            b  = (c < IMG_W) ? sh[0] : 1'b0;
            w  = (w << 1) | WIN_W'(b);
        end
        return w;
    endfunction

    assign tick = (pre_cnt >= speed);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= M_STATIC;
            pre_cnt <= '0;
            blank   <= 1'b0;
            offset  <= '0;
            wrap    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    offset  <= '0;
                    pre_cnt <= '0;
                    blank   <= 1'b0;
                    if (start && !stop) begin
                        state  <= RUN;
                        mode_q <= mode_t'(mode);
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= PAUSED;
                        busy  <= 1'b0;
                    end else begin
                        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
                        if (tick) begin
                            case (mode_q)
                                M_WRAP: begin
                                    offset <= step_offset(offset, WRAP_LAST);
                                    wrap   <= (offset == WRAP_LAST);
                                end
                                M_GAP: begin
                                    offset <= step_offset(offset, GAP_LAST);
                                    wrap   <= (offset == GAP_LAST);
                                end
                                M_BLINK: blank <= ~blank;
                                default: ;
                            endcase
                        end
                    end
                end
                PAUSED: begin
                    if (stop) begin
                        state   <= IDLE;
                        offset  <= '0;
                        pre_cnt <= '0;
                        blank   <= 1'b0;
                    end else if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // C0 -> C1: address the ROM and freeze the scroll state seen by this row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
        end else begin
            vld_p1 <= bus.row_req;
            if (bus.row_req) addr_p1 <= bus.row_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.row_req) begin
            off_p1  <= offset;
            gap_p1  <= (mode_q == M_GAP);
            zero_p1 <= ((mode_q == M_BLINK) && blank) || !row_in_range(bus.row_addr);
        end
    end

    assign win_p1 = window(bus.rom_data, off_p1, gap_p1);

    // C1 -> C2: register the window out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) data_p2 <= zero_p1 ? '0 : win_p1;
        end
    end

    assign bus.rom_addr  = addr_p1;
    assign bus.row_data  = data_p2;
    assign bus.row_valid = vld_p2;
endmodule

// File: tb/tb_banner_scroller.sv
// Testbench for banner_scroller: directed phases plus random traffic checked
// against a behavioural model of scrolling, blinking and the 2-cycle row read.
module tb_banner_scroller;
    localparam int IMG_W  = 70;
    localparam int IMG_H  = 15;
    localparam int WIN_W  = 32;
    localparam int ADDR_W = 5;
    localparam int PRE_W  = 24;

    logic             clk = 1'b0;
    logic             rst_n, start, stop;
    logic [1:0]       mode;
    logic [PRE_W-1:0] speed;
    logic [7:0]       offset;
    logic             wrap, busy;

    always #5 clk = ~clk;

    banner_scroller_if #(.IMG_W(IMG_W), .WIN_W(WIN_W), .ADDR_W(ADDR_W)) bus ();

    logic [IMG_W-1:0] img [2**ADDR_W];
    assign bus.rom_data = img[bus.rom_addr];

    banner_scroller #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN_W(WIN_W),
                      .ADDR_W(ADDR_W), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .speed(speed), .offset(offset), .wrap(wrap), .busy(busy), .bus(bus.slave)
    );

    int n_tests, n_fail, n_wrap;
    bit auto_req;

    // model: state 0 idle, 1 running, 2 paused
    int m_st, m_off, m_cnt, m_md;
    bit m_blank, m_wrap, m_busy, p1_v, p2_v;
    logic [WIN_W-1:0] p1_d, m_row;
    logic [WIN_W-1:0] ra, rb;

    function automatic logic [WIN_W-1:0] exp_row(int row, int off, int md, bit blk);
        logic [WIN_W-1:0] r;
        logic [IMG_W-1:0] rowv, tmp;
        int c;
        r = '0;
        if (row >= IMG_H || (md == 3 && blk)) return r;
        rowv = img[ADDR_W'(row)];
        for (int j = 0; j < WIN_W; j++) begin
            if (md == 2) c = (off + j) % (IMG_W + WIN_W);
            else         c = (off + j) % IMG_W;
            r = r << 1;
            if (c < IMG_W) begin
                tmp = rowv >> (IMG_W - 1 - c);
                r[0] = tmp[0];
            end
        end
        return r;
    endfunction

    function automatic void model_edge();
        bit tk;
        if (!rst_n) begin
            m_st = 0; m_off = 0; m_cnt = 0; m_md = 0;
            m_blank = 0; m_wrap = 0; m_busy = 0;
            p1_v = 0; p2_v = 0; m_row = '0;
            return;
        end
        if (p1_v) m_row = p1_d;
        p2_v = p1_v;
        p1_v = bus.row_req;
        if (bus.row_req) p1_d = exp_row(int'(bus.row_addr), m_off, m_md, m_blank);
        m_wrap = 0;
        if (m_st == 0) begin
            m_off = 0; m_cnt = 0; m_blank = 0;
            if (start && !stop) begin m_st = 1; m_md = int'(mode); m_busy = 1; end
        end else if (m_st == 1) begin
            if (stop) begin
                m_st = 2; m_busy = 0;
            end else begin
                tk = (m_cnt >= int'(speed));
                m_cnt = tk ? 0 : m_cnt + 1;
                if (tk) begin
                    if (m_md == 1) begin
                        m_off = (m_off + 1) % IMG_W; m_wrap = (m_off == 0);
                    end else if (m_md == 2) begin
                        m_off = (m_off + 1) % (IMG_W + WIN_W); m_wrap = (m_off == 0);
                    end else if (m_md == 3) begin
                        m_blank = !m_blank;
                    end
                end
            end
        end else begin
            if (stop) begin
                m_st = 0; m_off = 0; m_cnt = 0; m_blank = 0;
            end else if (start) begin
                m_st = 1; m_busy = 1;
            end
        end
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("offset", 64'(offset), 64'(m_off));
        check("wrap", 64'(wrap), 64'(m_wrap));
        check("busy", 64'(busy), 64'(m_busy));
        check("row_valid", 64'(bus.row_valid), 64'(p2_v));
        check("row_data", 64'(bus.row_data), 64'(m_row));
        if (wrap === 1'b1) n_wrap++;
        if (auto_req) begin
            bus.row_req  = 1'($urandom_range(0, 1));
            bus.row_addr = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic req_off();
        auto_req = 1'b0; bus.row_req = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_wrap = 0; auto_req = 1'b0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; speed = '0;
        bus.row_req = 1'b0; bus.row_addr = '0;
        img[0] = {32'hFC0FC0FF, 38'b1_000000_111111_000000_111111_000000000000_1};
        for (int r = 1; r < 2**ADDR_W; r++)
            img[r] = IMG_W'({$urandom(), $urandom(), $urandom()});

        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        check("rst_offset", 64'(offset), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(bus.row_valid), 64'd0);
        check("rst_data", 64'(bus.row_data), 64'd0);

        // STATIC
        mode = 2'd0; pulse_start();
        check("static_busy", 64'(busy), 64'd1);
        bus.row_req = 1'b1; bus.row_addr = 5'd0; cyc();
        bus.row_req = 1'b0; cyc();
        check("static_r0_valid", 64'(bus.row_valid), 64'd1);
        check("static_r0", 64'(bus.row_data), 64'hFC0FC0FF);
        bus.row_req = 1'b1; bus.row_addr = 5'd20; cyc();
        bus.row_req = 1'b0; cyc();
        check("static_r20_valid", 64'(bus.row_valid), 64'd1);
        check("static_r20", 64'(bus.row_data), 64'd0);
        auto_req = 1'b1; run(20); req_off();
        pulse_stop(); pulse_stop();

        // WRAP, speed 3
        mode = 2'd1; speed = PRE_W'(3); n_wrap = 0;
        pulse_start(); auto_req = 1'b1; run(300); req_off();
        check("wrap_pulses", 64'(n_wrap), 64'd1);
        pulse_stop(); pulse_stop();

        // GAP, speed 0
        mode = 2'd2; speed = '0; n_wrap = 0;
        pulse_start(); auto_req = 1'b1; run(49); req_off(); cyc();
        check("gap_off50", 64'(offset), 64'd50);
        bus.row_req = 1'b1; bus.row_addr = 5'd0; cyc();
        bus.row_req = 1'b0; cyc();
        check("gap_low12", 64'(bus.row_data[11:0]), 64'd0);
        auto_req = 1'b1; run(70); req_off();
        check("gap_pulses", 64'(n_wrap), 64'd1);
        pulse_stop(); pulse_stop();

        // BLINK, speed 0
        mode = 2'd3; n_wrap = 0;
        pulse_start();
        bus.row_req = 1'b1; bus.row_addr = 5'd0; cyc(); cyc();
        bus.row_req = 1'b0; ra = bus.row_data; cyc(); rb = bus.row_data;
        check("blink_or", 64'(ra | rb), 64'hFC0FC0FF);
        check("blink_and", 64'(ra & rb), 64'd0);
        auto_req = 1'b1; run(50); req_off();
        check("blink_offset", 64'(offset), 64'd0);
        check("blink_pulses", 64'(n_wrap), 64'd0);
        pulse_stop(); pulse_stop();

        // control sequencing, WRAP speed 0
        mode = 2'd1;
        pulse_start(); run(5); pulse_stop();
        check("pause_off", 64'(offset), 64'd5);
        check("pause_busy", 64'(busy), 64'd0);
        run(3);
        check("pause_hold", 64'(offset), 64'd5);
        pulse_start(); cyc();
        check("resume_off", 64'(offset), 64'd6);
        pulse_stop(); pulse_stop();
        check("idle_off", 64'(offset), 64'd0);
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0; cyc();
        check("both_busy", 64'(busy), 64'd0);
        pulse_start(); run(4); mode = 2'd3; run(6);
        check("mode_locked", 64'(offset), 64'd10);

        // reset while running with a read in flight
        run(7);
        check("pre_rst_off", 64'(offset), 64'd17);
        bus.row_req = 1'b1; bus.row_addr = 5'd0; cyc();
        bus.row_req = 1'b0; rst_n = 1'b0; cyc(); cyc();
        check("rst2_offset", 64'(offset), 64'd0);
        check("rst2_busy", 64'(busy), 64'd0);
        check("rst2_valid", 64'(bus.row_valid), 64'd0);
        check("rst2_data", 64'(bus.row_data), 64'd0);
        rst_n = 1'b1; cyc();
        check("rst2_no_valid", 64'(bus.row_valid), 64'd0);

        // random control and traffic
        auto_req = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) speed = PRE_W'($urandom_range(0, 4));
            cyc();
        end
        start = 1'b0; stop = 1'b0; req_off(); run(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
